// File: rtl/ps2_tone_pkg.sv
// Shared constants, prefix FSM states and the key-to-pitch lookup for the
// PS/2 polyphonic tone generator.
package ps2_tone_pkg;

  localparam int HALF_W = 17;

  // The key table holds half-periods at this clock; other clocks are rescaled
  // with round-to-nearest so the pitch stays the same.
  localparam int unsigned REF_CLK_HZ = 50_000_000;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_C4 = 8'h15;
  localparam logic [7:0] SC_D4 = 8'h1D;
  localparam logic [7:0] SC_E4 = 8'h24;
  localparam logic [7:0] SC_F4 = 8'h2D;
  localparam logic [7:0] SC_G4 = 8'h2C;
  localparam logic [7:0] SC_A4 = 8'h35;
  localparam logic [7:0] SC_B4 = 8'h3C;
  localparam logic [7:0] SC_C5 = 8'h43;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } prefix_state_t;

  // Rescale a reference half-period to the actual clock; arguments are constants
  // in every call site, so this folds away.
  function automatic logic [HALF_W-1:0] scale_half(input int unsigned ref_half,
                                                   input int unsigned clk_hz);
    return HALF_W'((64'(ref_half) * 64'(clk_hz) + 64'(REF_CLK_HZ / 2)) / 64'(REF_CLK_HZ));
  endfunction

  // Returns {hit, half_period}; hit is 0 for any scancode outside the Q-row map.
  function automatic logic [HALF_W:0] key_half_period(input logic [7:0] k,
                                                      input int unsigned clk_hz);
    logic              hit;
    logic [HALF_W-1:0] half;
    hit  = 1'b1;
    half = '0;
    case (k)
      SC_C4:   half = scale_half(95556, clk_hz);
      SC_D4:   half = scale_half(85131, clk_hz);
      SC_E4:   half = scale_half(75843, clk_hz);
      SC_F4:   half = scale_half(71586, clk_hz);
      SC_G4:   half = scale_half(63776, clk_hz);
      SC_A4:   half = scale_half(56818, clk_hz);
      SC_B4:   half = scale_half(50619, clk_hz);
      SC_C5:   half = scale_half(47778, clk_hz);
      default: hit  = 1'b0;
    endcase
    return {hit, half};
  endfunction

endpackage

// File: rtl/ps2_tone_voice.sv
// One square-wave voice: remembers which key it plays and toggles its phase
// every half-period while active.
module ps2_tone_voice
  import ps2_tone_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              stop,
  input  logic [7:0]        load_key,
  input  logic [HALF_W-1:0] load_half,
  output logic [7:0]        key,
  output logic              active,
  output logic              phase
);

  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] count;

  // Load starts the note high with a full half-period; stop silences it; otherwise count down and toggle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key    <= '0;
      half   <= '0;
      count  <= '0;
      active <= 1'b0;
      phase  <= 1'b0;
    end else if (load) begin
      key    <= load_key;
      half   <= load_half;
      count  <= load_half;
      active <= 1'b1;
      phase  <= 1'b1;
    end else if (stop) begin
      active <= 1'b0;
      phase  <= 1'b0;
    end else if (active) begin
      if (count == HALF_W'(1)) begin
        count <= half;
        phase <= ~phase;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_poly_tone.sv
// PS/2 scancode driven polyphonic square-wave generator: prefix decoding,
// voice allocation, sample-rate divider and saturating mixer.
module ps2_poly_tone
  import ps2_tone_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 48_000,
  parameter int VOICES    = 4,
  parameter int SAMPLE_W  = 16,
  parameter int AMPLITUDE = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_data,
  input  logic [7:0]                 data,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       wr,
  output logic [VOICES-1:0]          voice_active,
  output logic [7:0]                 last_key,
  output logic                       dropped
);

  localparam int TICK  = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int ACC_W = SAMPLE_W + ((VOICES > 1) ? $clog2(VOICES) : 0);

  localparam logic signed [ACC_W-1:0] AMP     = ACC_W'(AMPLITUDE);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic [DIV_W-1:0] div;
  logic             tick;

  prefix_state_t     state;
  logic [HALF_W:0]   lut;
  logic              key_hit;
  logic [HALF_W-1:0] key_half;
  logic              make_req;
  logic              brk_req;

  logic [7:0]        voice_key [VOICES];
  logic [VOICES-1:0] voice_on;
  logic [VOICES-1:0] voice_phase;
  logic [VOICES-1:0] hold_vec;
  logic [VOICES-1:0] free_vec;
  logic              free_found;
  logic [VOICES-1:0] load_vec;
  logic [VOICES-1:0] stop_vec;

  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] sample_next;

  assign tick = (div == DIV_W'(TICK - 1));

  // Free-running sample-rate divider, wrapping to 0 on each tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign lut      = key_half_period(data, CLK_HZ);
  assign key_hit  = lut[HALF_W];
  assign key_half = lut[HALF_W-1:0];

  assign make_req = valid_data && (state == S_IDLE) && (data != SC_BREAK) &&
                    (data != SC_EXT) && key_hit;
  assign brk_req  = valid_data && (state == S_BRK);

  // Prefix tracking for break (F0) and extended (E0) sequences; extended keys are swallowed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (valid_data) begin
      case (state)
        S_IDLE: begin
          if (data == SC_BREAK) begin
            state <= S_BRK;
          end else if (data == SC_EXT) begin
            state <= S_EXT;
          end
        end
        S_BRK:     state <= S_IDLE;
        S_EXT:     state <= (data == SC_BREAK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Find the voice already holding this byte and the lowest-numbered idle voice.
  always_comb begin
    hold_vec   = '0;
    free_vec   = '0;
    free_found = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      hold_vec[v] = voice_on[v] && (voice_key[v] == data);
      if (!voice_on[v] && !free_found) begin
        free_vec[v] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign load_vec = (make_req && (hold_vec == '0)) ? free_vec : '0;
  assign stop_vec = brk_req ? hold_vec : '0;

  for (genvar g = 0; g < VOICES; g++) begin : gen_voice
    ps2_tone_voice u_voice (
      .clock     (clock),
      .reset     (reset),
      .load      (load_vec[g]),
      .stop      (stop_vec[g]),
      .load_key  (data),
      .load_half (key_half),
      .key       (voice_key[g]),
      .active    (voice_on[g]),
      .phase     (voice_phase[g])
    );
  end

  assign voice_active = voice_on;

  // Remember the last key that got a voice and flag makes that found every voice busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_key <= 8'h00;
      dropped  <= 1'b0;
    end else begin
      dropped <= make_req && (hold_vec == '0) && !free_found;
      if (|load_vec) begin
        last_key <= data;
      end
    end
  end

  // Sum +/-AMPLITUDE over the sounding voices and clamp into the output range.
  always_comb begin
    acc = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (voice_on[v]) begin
        acc = voice_phase[v] ? (acc + AMP) : (acc - AMP);
      end
    end
    if (acc > SAT_MAX) begin
      sample_next = SAMPLE_W'(SAT_MAX);
    end else if (acc < SAT_MIN) begin
      sample_next = SAMPLE_W'(SAT_MIN);
    end else begin
      sample_next = SAMPLE_W'(acc);
    end
  end

  // Capture the mix and raise wr for one cycle on every sample tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample <= '0;
      wr     <= 1'b0;
    end else begin
      wr <= tick;
      if (tick) begin
        sample <= sample_next;
      end
    end
  end

endmodule

// File: tb/tb_ps2_poly_tone.sv
// Self-checking bench for ps2_poly_tone: directed table, hand sequences for
// tick/byte collisions, reset and saturation, plus a randomized byte stream
// checked against a time-based note model.
module tb_ps2_poly_tone;

  localparam int CLK_HZ    = 500_000;
  localparam int SAMPLE_HZ = 48_000;
  localparam int TICK      = CLK_HZ / SAMPLE_HZ;
  localparam int NV        = 4;
  localparam int AMP       = 4096;
  localparam int AMP2      = 8192;

  logic               clock;
  logic               reset;
  logic               valid_data;
  logic [7:0]         data;
  logic signed [15:0] sample;
  logic               wr;
  logic [NV-1:0]      voice_active;
  logic [7:0]         last_key;
  logic               dropped;

  logic               valid2;
  logic [7:0]         data2;
  logic signed [15:0] sample2;
  logic               wr2;
  logic [7:0]         active2;
  logic [7:0]         last2;
  logic               dropped2;

  ps2_poly_tone #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .VOICES(NV), .SAMPLE_W(16), .AMPLITUDE(AMP)
  ) dut (
    .clock(clock), .reset(reset), .valid_data(valid_data), .data(data),
    .sample(sample), .wr(wr), .voice_active(voice_active), .last_key(last_key),
    .dropped(dropped)
  );

  ps2_poly_tone #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .VOICES(8), .SAMPLE_W(16), .AMPLITUDE(AMP2)
  ) dut8 (
    .clock(clock), .reset(reset), .valid_data(valid2), .data(data2),
    .sample(sample2), .wr(wr2), .voice_active(active2), .last_key(last2),
    .dropped(dropped2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] key_codes [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
  int         key_semis [8] = '{0, 2, 4, 5, 7, 9, 11, 12};

  // Reference model: each sounding note remembers the edge it started on and its half-period.
  int         edge_cnt;
  int         exp_sample;
  int         drop_seen;
  bit         m_on    [NV];
  logic [7:0] m_key   [NV];
  int         m_start [NV];
  int         m_half  [NV];
  bit         m_pend_brk, m_pend_ext, m_pend_ext_brk;
  logic [7:0] m_last;
  bit         m_drop;

  typedef struct {
    string      name;
    logic [47:0] seq;
    int         n;
    logic [3:0] exp_active;
    logic [7:0] exp_last;
    int         exp_drops;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: actual=%0d required=%0d", name, edge_cnt, actual, required);
    end
  endtask

  // Half-period of an equal-tempered note, in clocks, rounded to nearest.
  function automatic int exp_half(input int semi);
    real f;
    f = 440.0 * (2.0 ** ((semi - 9) / 12.0));
    return $rtoi(CLK_HZ / (2.0 * f) + 0.5);
  endfunction

  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (key_codes[i] == b) return i;
    end
    return -1;
  endfunction

  function automatic int model_active();
    int r = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_on[v]) r |= (1 << v);
    end
    return r;
  endfunction

  // Mix as seen by a sample taken from the state after edge e_prev.
  function automatic int model_mix(input int e_prev);
    int sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_on[v]) begin
        if ((((e_prev - m_start[v]) / m_half[v]) % 2) == 0) sum += AMP;
        else sum -= AMP;
      end
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_on[v] = 0;
      m_key[v] = 8'h00;
      m_start[v] = 0;
      m_half[v] = 1;
    end
    m_pend_brk = 0;
    m_pend_ext = 0;
    m_pend_ext_brk = 0;
    m_last = 8'h00;
    m_drop = 0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    int  k;
    int  slot;
    bit  held;
    k = key_index(d);
    if (m_pend_brk) begin
      m_pend_brk = 0;
      for (int v = 0; v < NV; v++) begin
        if (m_on[v] && m_key[v] == d) m_on[v] = 0;
      end
    end else if (m_pend_ext) begin
      m_pend_ext = 0;
      m_pend_ext_brk = (d == 8'hF0);
    end else if (m_pend_ext_brk) begin
      m_pend_ext_brk = 0;
    end else if (d == 8'hF0) begin
      m_pend_brk = 1;
    end else if (d == 8'hE0) begin
      m_pend_ext = 1;
    end else if (k >= 0) begin
      held = 0;
      for (int v = 0; v < NV; v++) begin
        if (m_on[v] && m_key[v] == d) held = 1;
      end
      if (!held) begin
        slot = -1;
        for (int v = 0; v < NV; v++) begin
          if (!m_on[v] && slot < 0) slot = v;
        end
        if (slot < 0) begin
          m_drop = 1;
        end else begin
          m_on[slot] = 1;
          m_key[slot] = d;
          m_start[slot] = edge_cnt;
          m_half[slot] = exp_half(key_semis[k]);
          m_last = d;
        end
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the rising edge, compare after it.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    int snap;
    bit due;
    valid_data = v;
    data = d;
    due = ((edge_cnt + 1) % TICK) == 0;
    snap = model_mix(edge_cnt);
    @(posedge clock);
    edge_cnt++;
    if (due) exp_sample = snap;
    m_drop = 0;
    if (v) model_byte(d);
    @(negedge clock);
    valid_data = 1'b0;
    if (dropped) drop_seen++;
    checkOutput("wr", int'(wr), int'(due));
    checkOutput("sample", int'(sample), exp_sample);
    checkOutput("voice_active", int'(voice_active), model_active());
    checkOutput("last_key", int'(last_key), int'(m_last));
    checkOutput("dropped", int'(dropped), int'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_data = 1'b0;
    valid2 = 1'b0;
    #1;
    checkOutput("rst_sample", int'(sample), 0);
    checkOutput("rst_wr", int'(wr), 0);
    checkOutput("rst_active", int'(voice_active), 0);
    checkOutput("rst_last_key", int'(last_key), 0);
    checkOutput("rst_dropped", int'(dropped), 0);
    checkOutput("rst_active8", int'(active2), 0);
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    edge_cnt = 0;
    exp_sample = 0;
    drop_seen = 0;
  endtask

  initial begin
    reset = 1'b1;
    valid_data = 1'b0;
    data = 8'h00;
    valid2 = 1'b0;
    data2 = 8'h00;
    edge_cnt = 0;
    exp_sample = 0;
    drop_seen = 0;
    model_clear();

    vecs[0] = '{"single",      48'h15,             1, 4'b0001, 8'h15, 0};
    vecs[1] = '{"make_break",  48'h15_F0_15,       3, 4'b0000, 8'h15, 0};
    vecs[2] = '{"all_busy",    48'h15_1D_24_2D_2C, 5, 4'b1111, 8'h2D, 1};
    vecs[3] = '{"unmapped",    48'hAB_DF_4D_5B_E0_15, 6, 4'b0000, 8'h00, 0};
    vecs[4] = '{"typematic",   48'h15_15,          2, 4'b0001, 8'h15, 0};
    vecs[5] = '{"typ_break",   48'h15_15_F0_15,    4, 4'b0000, 8'h15, 0};
    vecs[6] = '{"ext_break",   48'hE0_F0_15_35,    4, 4'b0001, 8'h35, 0};
    vecs[7] = '{"reuse_voice", 48'h15_1D_F0_15_24, 5, 4'b0011, 8'h24, 0};
    vecs[8] = '{"break_none",  48'hF0_1D_35,       3, 4'b0001, 8'h35, 0};
    vecs[9] = '{"rebreak",     48'h3C_F0_3C_3C,    4, 4'b0001, 8'h3C, 0};

    @(negedge clock);

    // Directed table of byte sequences.
    for (int i = 0; i < 10; i++) begin
      logic [47:0] s;
      do_reset();
      s = vecs[i].seq;
      for (int b = 0; b < vecs[i].n; b++) begin
        applyStimulus(1'b1, s[8*(vecs[i].n-1-b) +: 8]);
        idle(1);
      end
      idle(3);
      checkOutput({vecs[i].name, "_active"}, int'(voice_active), int'(vecs[i].exp_active));
      checkOutput({vecs[i].name, "_last"}, int'(last_key), int'(vecs[i].exp_last));
      checkOutput({vecs[i].name, "_drops"}, drop_seen, vecs[i].exp_drops);
    end

    // Byte landing on the tick edge: that sample still sees the silent voice.
    do_reset();
    idle(TICK - 1);
    applyStimulus(1'b1, 8'h15);
    checkOutput("collide_wr", int'(wr), 1);
    checkOutput("collide_sample", int'(sample), 0);
    checkOutput("collide_active", int'(voice_active), 1);
    idle(TICK);
    checkOutput("collide_next", int'(sample), AMP);

    // Sustained note over several half-periods, then release to silence.
    idle(2 * exp_half(0) + 3 * TICK);
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, 8'h15);
    idle(2 * TICK);
    checkOutput("released_sample", int'(sample), 0);

    // Reset while three voices sound and a break prefix is pending.
    applyStimulus(1'b1, 8'h15);
    applyStimulus(1'b1, 8'h1D);
    applyStimulus(1'b1, 8'h24);
    applyStimulus(1'b1, 8'hF0);
    do_reset();
    idle(TICK - 1);
    checkOutput("first_wr_early", int'(wr), 0);
    idle(1);
    checkOutput("first_wr", int'(wr), 1);
    applyStimulus(1'b1, 8'h35);
    idle(2);
    checkOutput("after_rst_active", int'(voice_active), 1);
    checkOutput("after_rst_last", int'(last_key), 8'h35);

    // Randomized byte stream against the model.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r <= 5) b = key_codes[$urandom_range(0, 7)];
      else if (r <= 7) b = 8'hF0;
      else if (r == 8) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, b);
      idle($urandom_range(0, 2));
    end
    idle(50);

    // Eight voices all high at once must clip to the positive rail.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      valid2 = 1'b1;
      data2 = key_codes[k];
      applyStimulus(1'b0, 8'h00);
      valid2 = 1'b0;
    end
    begin
      bit seen = 0;
      for (int c = 0; c < 2 * TICK && !seen; c++) begin
        applyStimulus(1'b0, 8'h00);
        if (wr2) begin
          seen = 1;
          checkOutput("sat_sample", int'(sample2), 32767);
        end
      end
      checkOutput("sat_wr_seen", int'(seen), 1);
    end
    checkOutput("sat_active", int'(active2), 8'hFF);
    checkOutput("sat_last", int'(last2), 8'h43);
    checkOutput("sat_dropped", int'(dropped2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
